// File: rtl/wb_seq_multich.sv
// wb_seq_multich: write-back sequencer that copies up to DEPTH words from N_CH
// result RAMs (shared read address) into SDRAM, one single-word write per enabled
// channel per RAM address.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start, i_abort      run start pulse (IDLE only), abort request
//   i_len, i_chEn         words per channel (clamped to DEPTH), channel mask
//   i_baseAddr            per-channel SDRAM base, channel c at [c*ADDR_W +: ADDR_W]
//   i_sdramReady          SDRAM write-complete strobe
//   o_addrToRam, o_ramRd  shared RAM read address and read strobe
//   o_addrToSdram         SDRAM write address
//   o_wrSdram             SDRAM write request pulse
//   o_selData             data-mux select (current channel)
//   o_busy, o_finish      status: busy outside IDLE, one-cycle done pulse
//   o_error               sticky: last run ended by timeout or abort
module wb_seq_multich #(
    parameter int unsigned N_CH    = 3,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DEPTH_W = 12,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned TO_CYC  = 1023,
    localparam int unsigned SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [DEPTH_W:0]         i_len,
    input  logic [N_CH-1:0]          i_chEn,
    input  logic [N_CH*ADDR_W-1:0]   i_baseAddr,
    input  logic                     i_sdramReady,
    output logic [DEPTH_W-1:0]       o_addrToRam,
    output logic                     o_ramRd,
    output logic [ADDR_W-1:0]        o_addrToSdram,
    output logic                     o_wrSdram,
    output logic [SEL_W-1:0]         o_selData,
    output logic                     o_busy,
    output logic                     o_finish,
    output logic                     o_error
);

    localparam int unsigned LEN_W = DEPTH_W + 1;
    localparam int unsigned TO_W  = $clog2(TO_CYC + 1);
    localparam int unsigned LAT_W = $clog2(RAM_LAT + 1);
    localparam logic [LEN_W-1:0] DEPTH = {1'b1, {DEPTH_W{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RD, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

    state_t                   state, state_n;
    logic [LEN_W-1:0]         len_q, len_n, len_clamp;
    logic [N_CH-1:0]          mask_q, mask_n;
    logic [N_CH*ADDR_W-1:0]   base_q, base_n;
    logic [LEN_W-1:0]         idx_q, idx_n;
    logic [SEL_W-1:0]         ch_q, ch_n;
    logic [LAT_W-1:0]         lat_q, lat_n;
    logic [TO_W-1:0]          to_q, to_n;
    logic                     err_n;

    logic [SEL_W-1:0]         lowest_ch, higher_ch;
    logic                     higher_found;
    logic [ADDR_W-1:0]        base_sel;

    logic [DEPTH_W-1:0]       ram_addr_n;
    logic                     ram_rd_n, wr_n, busy_n, finish_n;
    logic [ADDR_W-1:0]        sd_addr_n;
    logic [SEL_W-1:0]         sel_n;

    assign len_clamp = (i_len > DEPTH) ? DEPTH : i_len;

    // Lowest enabled channel, and the next enabled channel above the current one
    always_comb begin
        lowest_ch    = '0;
        higher_ch    = '0;
        higher_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lowest_ch = SEL_W'(i);
                if (i > int'(ch_q)) begin
                    higher_ch    = SEL_W'(i);
                    higher_found = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic; outputs are registered aligned with state
    always_comb begin
        state_n = state;
        len_n   = len_q;
        mask_n  = mask_q;
        base_n  = base_q;
        idx_n   = idx_q;
        ch_n    = ch_q;
        lat_n   = lat_q;
        to_n    = to_q;
        err_n   = o_error;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    len_n  = len_clamp;
                    mask_n = i_chEn;
                    base_n = i_baseAddr;
                    err_n  = 1'b0;
                    idx_n  = '0;
                    ch_n   = '0;
                    lat_n  = '0;
                    to_n   = '0;
                    state_n = (len_clamp == '0 || i_chEn == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                ch_n = lowest_ch;
                if (lat_q == LAT_W'(RAM_LAT - 1)) begin
                    lat_n   = '0;
                    state_n = S_ISSUE;
                end else begin
                    lat_n = lat_q + LAT_W'(1);
                end
            end
            S_ISSUE: begin
                to_n    = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (i_sdramReady) begin
                    to_n    = '0;
                    state_n = S_NEXT;
                end else if (to_q == TO_W'(TO_CYC - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    to_n = to_q + TO_W'(1);
                end
            end
            S_NEXT: begin
                if (higher_found) begin
                    ch_n    = higher_ch;
                    state_n = S_ISSUE;
                end else if (idx_q + LEN_W'(1) == len_q) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx_q + LEN_W'(1);
                    state_n = S_RD;
                end
            end
            S_DONE: begin
                idx_n   = '0;
                ch_n    = '0;
                lat_n   = '0;
                to_n    = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort overrides everything, including a coincident ready or timeout
        if (i_abort && (state == S_RD || state == S_ISSUE ||
                        state == S_WAIT || state == S_NEXT)) begin
            err_n   = 1'b1;
            state_n = S_DONE;
        end

        base_sel   = base_q[int'(ch_n) * ADDR_W +: ADDR_W];
        ram_rd_n   = (state_n == S_RD) && (state != S_RD);
        wr_n       = (state_n == S_ISSUE);
        busy_n     = (state_n != S_IDLE);
        finish_n   = (state == S_DONE);
        ram_addr_n = (state_n == S_IDLE) ? '0 : idx_n[DEPTH_W-1:0];
        if (state_n == S_ISSUE || state_n == S_WAIT) begin
            sd_addr_n = base_sel + ADDR_W'(idx_n);
            sel_n     = ch_n;
        end else begin
            sd_addr_n = '0;
            sel_n     = '0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            len_q         <= '0;
            mask_q        <= '0;
            base_q        <= '0;
            idx_q         <= '0;
            ch_q          <= '0;
            lat_q         <= '0;
            to_q          <= '0;
            o_addrToRam   <= '0;
            o_ramRd       <= 1'b0;
            o_addrToSdram <= '0;
            o_wrSdram     <= 1'b0;
            o_selData     <= '0;
            o_busy        <= 1'b0;
            o_finish      <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            state         <= state_n;
            len_q         <= len_n;
            mask_q        <= mask_n;
            base_q        <= base_n;
            idx_q         <= idx_n;
            ch_q          <= ch_n;
            lat_q         <= lat_n;
            to_q          <= to_n;
            o_addrToRam   <= ram_addr_n;
            o_ramRd       <= ram_rd_n;
            o_addrToSdram <= sd_addr_n;
            o_wrSdram     <= wr_n;
            o_selData     <= sel_n;
            o_busy        <= busy_n;
            o_finish      <= finish_n;
            o_error       <= err_n;
        end
    end

endmodule
